// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and IRQ.
// Define TC_AUTORELOAD_EN to enable Mode 1 auto-reload; otherwise every mode is one-shot.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    state_e      state_q, state_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic [1:0]  ctrl_mode_q, ctrl_mode_d;
    logic        ctrl_im_q, ctrl_im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q, irq_d;

    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_mode;
    logic        unused_addr;

    assign sel         = Addr[3:2];
    assign wr_ctrl     = WE && (sel == REG_CTRL);
    assign wr_preset   = WE && (sel == REG_PRESET);
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

`ifdef TC_AUTORELOAD_EN
    assign auto_mode = (ctrl_mode_q == 2'd1);
`else
    assign auto_mode = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ctrl_en_d   = ctrl_en_q;
        ctrl_mode_d = ctrl_mode_q;
        ctrl_im_d   = ctrl_im_q;
        preset_d    = preset_q;
        count_d     = count_q;
        irq_flag_d  = irq_flag_q;

        // A sticky one-shot flag is acknowledged by any CTRL/PRESET write;
        // a terminal count in this same cycle re-sets it below.
        if ((wr_ctrl || wr_preset) && !auto_mode) begin
            irq_flag_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (ctrl_en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_en_q) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    state_d    = INT;
                    irq_flag_d = 1'b1;
                end
            end
            INT: begin
`ifdef TC_AUTORELOAD_EN
                if (auto_mode) begin
                    state_d    = LOAD;
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_en_d = 1'b0;
                    state_d   = IDLE;
                end
`else
                ctrl_en_d = 1'b0;
                state_d   = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // CPU writes come last so they win over the FSM clearing En.
        if (wr_ctrl) begin
            ctrl_en_d   = Din[0];
            ctrl_mode_d = Din[2:1];
            ctrl_im_d   = Din[3];
        end
        if (wr_preset) begin
            preset_d = Din;
        end

        irq_d = irq_flag_d & ctrl_im_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= 2'd0;
            ctrl_im_q   <= 1'b0;
            preset_q    <= 32'd0;
            count_q     <= 32'd0;
            irq_flag_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_mode_q <= ctrl_mode_d;
            ctrl_im_q   <= ctrl_im_d;
            preset_q    <= preset_d;
            count_q     <= count_d;
            irq_flag_q  <= irq_flag_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        unique case (sel)
            REG_CTRL:   Dout = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
            REG_PRESET: Dout = preset_q;
            REG_COUNT:  Dout = count_q;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_q;

endmodule

// File: doc/timer_counter.md
# timer_counter

- Memory-mapped down-counting timer: the responder on the device side of the CPU-to-peripheral system bridge.
- Two instances sit at 0x7F00–0x7F0B and 0x7F10–0x7F1B; the bridge decodes the address and drives each instance's `WE`.
- Each instance exposes CTRL, PRESET and COUNT registers, counts down from PRESET, and raises `IRQ` for the CPU's interrupt logic.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `Addr`  in  32  word address from CPU; only `Addr[3:2]` is decoded.
- `WE`  in  1  write enable from bridge, already qualified by address range.
- `Din`  in  32  write data.
- `Dout`  out  32  read data, combinational from `Addr[3:2]`.
- `IRQ`  out  1  interrupt request, registered.

## Operation
Register map (`Addr[3:2]`):
- `00` CTRL: `[0]` En, `[2:1]` Mode, `[3]` IM (interrupt mask, 1 = enabled). Bits `[31:4]` read 0; writes to them are ignored.
- `01` PRESET: 32-bit, read/write.
- `10` COUNT: 32-bit, read-only; writes are ignored.
- `11`: reads 0; writes are ignored.

Mode encoding:
- Mode 1 = auto-reload.
- Mode 0, 2 and 3 = one-shot.

FSM states: IDLE, LOAD, CNT, INT.
- IDLE: if En=1, go to LOAD.
- LOAD: COUNT ← PRESET; go to CNT.
- CNT:
  - If En=0: go to IDLE, COUNT held.
  - Else if COUNT > 1: COUNT ← COUNT−1, stay in CNT.
  - Else: COUNT ← 0; go to INT; set irq_flag.
- INT, one-shot: clear CTRL.En; go to IDLE; irq_flag stays set.
- INT, auto-reload: go to LOAD; clear irq_flag. En is unchanged.

Interrupt logic:
- `IRQ` = irq_flag & IM, registered.
- In one-shot mode, irq_flag is cleared by any CPU write to CTRL or PRESET.

Write semantics and conflicts:
- A CPU write to CTRL in the same cycle that INT clears En: the CPU write wins.
- A PRESET write while counting does not change COUNT; it takes effect at the next LOAD.
- PRESET = 0 behaves like PRESET = 1: LOAD, then CNT one cycle, then INT.
- COUNT never wraps below 0.

Reset:
- CTRL, PRESET, COUNT = 0; state IDLE; irq_flag = 0; `IRQ` = 0.
- Asserting `reset` mid-count clears all state on that edge.

## Timing
- Reads are zero-latency: `Dout` reflects the register value at the start of the cycle.
- Writes are visible to reads in the next cycle.
- En written at edge t with PRESET = N ≥ 1:
  - state LOAD after edge t+1;
  - COUNT = N after edge t+2;
  - COUNT = 1 after edge t+N+1;
  - INT entered after edge t+N+2, with `IRQ` = 1 from that edge (if IM = 1).
- One-shot: `IRQ` stays high until a CTRL or PRESET write. CTRL.En reads 0 from edge t+N+3.
- Auto-reload: `IRQ` is a one-cycle pulse, repeating every N+2 cycles.
- Clearing En during CNT: COUNT freezes from the next edge. Re-setting En restarts with LOAD; COUNT does not resume.

## Configuration
- `TC_AUTORELOAD_EN` defined: Mode 1 behaves as auto-reload, as described above.
- `TC_AUTORELOAD_EN` undefined: every Mode value behaves as one-shot.
  - CTRL[2:1] still stores and reads back whatever was written.
  - The auto-reload INT→LOAD path and the pulse logic are not synthesized.

## Test plan
- Reset → all register reads 0, `IRQ` = 0. Then write PRESET = 5 and CTRL = 0x9 (En, one-shot, IM) → COUNT reads 5,4,3,2,1,0 on consecutive cycles. `IRQ` rises 7 cycles after the CTRL write edge and stays high. CTRL reads 0x8 afterward.
- Continuing the previous case: write CTRL = 0x8 → `IRQ` drops the next cycle. Write COUNT = 0x1234 → COUNT is unchanged.
- PRESET = 3, CTRL = 0xB (auto-reload, IM) → `IRQ` one-cycle pulses every 5 cycles for ≥ 3 periods. With the macro undefined → a single sticky `IRQ` and En cleared.
- PRESET = 10, start, clear En after COUNT = 7 → COUNT holds 7, no `IRQ`. Re-enable → reloads 10.
- PRESET = 4, CTRL = 0x1 (IM = 0) → terminal count reached, `IRQ` stays 0. Then write CTRL = 0x8 → `IRQ` stays 0, because the write clears irq_flag.
- Assert `reset` while COUNT = 3 in auto-reload → next cycle all reads are 0, `IRQ` = 0, no further pulses. Also: a read at `Addr[3:2]` = 11 returns 0.
